// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin arbiter sharing two register-file write ports among four producers
module regfile_wb_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req_valid,
  input  logic [19:0]  req_addr,
  input  logic [127:0] req_data,
  output logic [3:0]   req_ready,
  output logic         write_en_0,
  output logic         write_en_1,
  output logic [31:0]  write_addr_0,
  output logic [31:0]  write_addr_1,
  output logic [31:0]  write_data_0,
  output logic [31:0]  write_data_1,
  output logic [1:0]   rr_ptr
);

  localparam int NREQ = 4;

  logic [4:0]  addr_a [NREQ];
  logic [31:0] data_a [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_a[i] = req_addr[5*i +: 5];
    assign data_a[i] = req_data[32*i +: 32];
  end

  logic        write_en_0_q, write_en_0_d;
  logic        write_en_1_q, write_en_1_d;
  logic [31:0] write_addr_0_q, write_addr_0_d;
  logic [31:0] write_addr_1_q, write_addr_1_d;
  logic [31:0] write_data_0_q, write_data_0_d;
  logic [31:0] write_data_1_q, write_data_1_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;

  logic        g0_vld, g1_vld;
  logic [1:0]  g0_idx, g1_idx, scan_idx;
  logic [3:0]  grant;

  // Slot 1 skips a requester targeting the same nonzero register as slot 0.
  always_comb begin
    g0_vld   = 1'b0;
    g1_vld   = 1'b0;
    g0_idx   = 2'd0;
    g1_idx   = 2'd0;
    scan_idx = 2'd0;
    for (int j = 0; j < NREQ; j++) begin
      scan_idx = rr_ptr_q + 2'(j);
      if (req_valid[scan_idx]) begin
        if (!g0_vld) begin
          g0_vld = 1'b1;
          g0_idx = scan_idx;
        end else if (!g1_vld &&
                     !((addr_a[scan_idx] == addr_a[g0_idx]) && (addr_a[g0_idx] != 5'd0))) begin
          g1_vld = 1'b1;
          g1_idx = scan_idx;
        end
      end
    end
    grant = 4'b0000;
    if (g0_vld) grant[g0_idx] = 1'b1;
    if (g1_vld) grant[g1_idx] = 1'b1;
  end

  assign req_ready = grant & {NREQ{~rst}};

  always_comb begin
    write_en_0_d   = 1'b0;
    write_en_1_d   = 1'b0;
    write_addr_0_d = write_addr_0_q;
    write_addr_1_d = write_addr_1_q;
    write_data_0_d = write_data_0_q;
    write_data_1_d = write_data_1_q;
    rr_ptr_d       = rr_ptr_q;
    if (g0_vld) begin
      write_en_0_d   = |addr_a[g0_idx];
      write_addr_0_d = {27'd0, addr_a[g0_idx]};
      write_data_0_d = data_a[g0_idx];
      rr_ptr_d       = g0_idx + 2'd1;
    end
    if (g1_vld) begin
      write_en_1_d   = |addr_a[g1_idx];
      write_addr_1_d = {27'd0, addr_a[g1_idx]};
      write_data_1_d = data_a[g1_idx];
      rr_ptr_d       = g1_idx + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_en_0_q   <= 1'b0;
      write_en_1_q   <= 1'b0;
      write_addr_0_q <= 32'd0;
      write_addr_1_q <= 32'd0;
      write_data_0_q <= 32'd0;
      write_data_1_q <= 32'd0;
      rr_ptr_q       <= 2'd0;
    end else begin
      write_en_0_q   <= write_en_0_d;
      write_en_1_q   <= write_en_1_d;
      write_addr_0_q <= write_addr_0_d;
      write_addr_1_q <= write_addr_1_d;
      write_data_0_q <= write_data_0_d;
      write_data_1_q <= write_data_1_d;
      rr_ptr_q       <= rr_ptr_d;
    end
  end

  assign write_en_0   = write_en_0_q;
  assign write_en_1   = write_en_1_q;
  assign write_addr_0 = write_addr_0_q;
  assign write_addr_1 = write_addr_1_q;
  assign write_data_0 = write_data_0_q;
  assign write_data_1 = write_data_1_q;
  assign rr_ptr       = rr_ptr_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  typedef struct packed {
    logic        en0;
    logic [31:0] a0;
    logic [31:0] d0;
    logic        en1;
    logic [31:0] a1;
    logic [31:0] d1;
    logic [1:0]  ptr;
  } wr_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [19:0]  req_addr;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         write_en_0, write_en_1;
  logic [31:0]  write_addr_0, write_addr_1, write_data_0, write_data_1;
  logic [1:0]   rr_ptr;

  int  checks = 0;
  int  errors = 0;
  wr_t es;
  wr_t exp_q[$];
  wr_t obs_w;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .write_en_0(write_en_0), .write_en_1(write_en_1),
    .write_addr_0(write_addr_0), .write_addr_1(write_addr_1),
    .write_data_0(write_data_0), .write_data_1(write_data_1),
    .rr_ptr(rr_ptr)
  );

  assign obs_w = {write_en_0, write_addr_0, write_data_0, write_en_1, write_addr_1, write_data_1, rr_ptr};

  task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    req_valid[i] = v;
    req_addr[i*5 +: 5] = a;
    req_data[i*32 +: 32] = d;
  endtask

  // Expected register-file writes for one cycle; unused port holds its old addr/data.
  task automatic exp_w(input logic g0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic g1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic [1:0] p);
    es.en0 = g0 && (a0 != 5'd0);
    if (g0) begin es.a0 = {27'd0, a0}; es.d0 = d0; end
    es.en1 = g1 && (a1 != 5'd0);
    if (g1) begin es.a1 = {27'd0, a1}; es.d1 = d1; end
    es.ptr = p;
    exp_q.push_back(es);
  endtask

  task automatic cmp_out(input string tag);
    wr_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=output expected=queued_entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, obs_w, e);
    end
  endtask

  task automatic step(input logic [3:0] exp_rdy, input string tag);
    #1;
    chk({tag, "_ready"}, req_ready, exp_rdy);
    @(posedge clk);
    #1;
    cmp_out({tag, "_write"});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0]  fa [4];
    logic [31:0] fd [4];
    int          gcnt [4];
    int          last [4];
    logic [1:0]  g0, g1;
    logic [3:0]  erdy;

    rst = 1'b1;
    req_valid = 4'b0;
    req_addr = '0;
    req_data = '0;
    es = '0;
    #3;
    chk("rst_out", obs_w, '0);
    chk("rst_ready", req_ready, 4'b0000);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 5'(i + 1), 32'hA0 + 32'(i));
    exp_w(1'b1, 5'd1, 32'hA0, 1'b1, 5'd2, 32'hA1, 2'd2);
    step(4'b0011, "full_a");
    set_req(0, 1'b0, 5'd1, 32'hA0);
    set_req(1, 1'b0, 5'd2, 32'hA1);
    exp_w(1'b1, 5'd3, 32'hA2, 1'b1, 5'd4, 32'hA3, 2'd0);
    step(4'b1100, "full_b");

    set_req(0, 1'b1, 5'd5, 32'h11);
    set_req(1, 1'b1, 5'd5, 32'h22);
    set_req(2, 1'b0, 5'd0, 32'h0);
    set_req(3, 1'b0, 5'd0, 32'h0);
    exp_w(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'h0, 2'd1);
    step(4'b0001, "conflict_a");
    set_req(0, 1'b0, 5'd5, 32'h11);
    exp_w(1'b1, 5'd5, 32'h22, 1'b0, 5'd0, 32'h0, 2'd2);
    step(4'b0010, "conflict_b");

    set_req(1, 1'b0, 5'd5, 32'h22);
    set_req(2, 1'b1, 5'd0, 32'hDEAD);
    exp_w(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'h0, 2'd3);
    step(4'b0100, "r0_drain");

    set_req(2, 1'b0, 5'd0, 32'h0);
    set_req(3, 1'b1, 5'd7, 32'h5);
    exp_w(1'b1, 5'd7, 32'h5, 1'b0, 5'd0, 32'h0, 2'd0);
    step(4'b1000, "single");

    set_req(3, 1'b0, 5'd7, 32'h5);
    exp_w(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 2'd0);
    step(4'b0000, "idle");

    set_req(1, 1'b1, 5'd9, 32'h91);
    set_req(2, 1'b1, 5'd9, 32'h92);
    exp_w(1'b1, 5'd9, 32'h91, 1'b0, 5'd0, 32'h0, 2'd2);
    step(4'b0010, "boundary_a");
    set_req(1, 1'b0, 5'd9, 32'h91);
    exp_w(1'b1, 5'd9, 32'h92, 1'b0, 5'd0, 32'h0, 2'd3);
    step(4'b0100, "boundary_b");

    set_req(2, 1'b0, 5'd9, 32'h92);
    set_req(0, 1'b1, 5'd0, 32'h31);
    set_req(1, 1'b1, 5'd0, 32'h32);
    exp_w(1'b1, 5'd0, 32'h31, 1'b1, 5'd0, 32'h32, 2'd2);
    step(4'b0011, "r0_pair");

    for (int i = 0; i < 4; i++) begin
      fa[i] = 5'(i + 1);
      fd[i] = 32'h100 * 32'(i);
      gcnt[i] = 0;
      last[i] = -1;
      set_req(i, 1'b1, fa[i], fd[i]);
    end
    for (int c = 0; c < 20; c++) begin
      g0 = es.ptr;
      g1 = es.ptr + 2'd1;
      erdy = 4'b0000;
      erdy[g0] = 1'b1;
      erdy[g1] = 1'b1;
      exp_w(1'b1, fa[g0], fd[g0], 1'b1, fa[g1], fd[g1], es.ptr + 2'd2);
      #1;
      chk("fair_ready", req_ready, erdy);
      for (int i = 0; i < 4; i++) begin
        if (req_ready[i]) begin
          chk("fair_gap", 1'((c - last[i]) <= 2), 1'b1);
          gcnt[i]++;
          last[i] = c;
        end
      end
      @(posedge clk);
      #1;
      cmp_out("fair_write");
      fd[g0] = fd[g0] + 32'd1;
      fd[g1] = fd[g1] + 32'd1;
      set_req(int'(g0), 1'b1, fa[g0], fd[g0]);
      set_req(int'(g1), 1'b1, fa[g1], fd[g1]);
    end
    for (int i = 0; i < 4; i++) chk("fair_count", 1'(gcnt[i] >= 9 && gcnt[i] <= 11), 1'b1);

    #2 rst = 1'b1;
    #1;
    chk("midrst_out", obs_w, '0);
    chk("midrst_ready", req_ready, 4'b0000);
    @(posedge clk);
    #1 rst = 1'b0;
    es = '0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 5'(i + 1), 32'hA0 + 32'(i));
    exp_w(1'b1, 5'd1, 32'hA0, 1'b1, 5'd2, 32'hA1, 2'd2);
    step(4'b0011, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
